simd_fp_int_add_pipe: RTL and testbench

//  LANES-wide SIMD adder for the systolic array accumulate path. Each beat is either FP16 or INT16.
//  - FP16 beats: IEEE half-precision add with round-to-nearest-even.
//  - INT16 beats: two's-complement add.

---
 rtl/simd_fp_int_add_pipe.sv | 270 +++++++++++++++++++++++++++
 tb/tb_simd_fp_int_add_pipe.sv | 318 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_fp_int_add_pipe.sv
// simd_fp_int_add_pipe
//   LANES-wide SIMD adder for the systolic-array accumulate path. Each beat
//   is either FP16 (IEEE half, round-to-nearest-even, subnormals flushed) or
//   INT16 (two's complement). The mode travels with the beat through a
//   three-stage valid/ready pipeline that stalls as a whole.
//     S1: decode, magnitude compare/swap, align smaller mantissa (G/R/S kept)
//     S2: 14-bit mantissa add/sub (FP) or 16-bit add (INT)
//     S3: normalise, round RNE, pack; result registered onto out_*
//
// Optional feature macro: INT_SAT_EN
//   defined   : INT16 lanes saturate to 16'h7FFF / 16'h8000 on overflow
//   undefined : INT16 lanes wrap modulo 2^16
//
// Ports
//   clk        in   rising-edge clock
//   rst_n      in   asynchronous active-low reset
//   in_valid   in   in_a/in_b/in_mode carry a beat
//   in_ready   out  beat accepted this cycle when in_valid is high
//   in_mode    in   0 = INT16 lanes, 1 = FP16 lanes
//   in_a/in_b  in   operands, lane i = bits [16i+15:16i]
//   out_valid  out  out_sum/out_ovf/out_mode carry a result
//   out_ready  in   downstream accepts the result
//   out_mode   out  mode of the beat on the output (0 when out_valid = 0)
//   out_sum    out  per-lane sums
//   out_ovf    out  per-lane overflow flags

module simd_fp_int_add_pipe #(
  parameter int LANES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 in_mode,
  input  logic [LANES*16-1:0]  in_a,
  input  logic [LANES*16-1:0]  in_b,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic                 out_mode,
  output logic [LANES*16-1:0]  out_sum,
  output logic [LANES-1:0]     out_ovf
);

  localparam logic [15:0] QNAN = 16'h7E00;

  logic                adv;
  logic                s1_valid, s2_valid, s3_valid;
  logic                s1_mode, s2_mode, s3_mode;
  logic [LANES*16-1:0] res_sum;
  logic [LANES-1:0]    res_ovf;

  // The whole pipe moves together; in_ready only looks at the output side.
  assign adv       = out_ready | ~s3_valid;
  assign in_ready  = adv;
  assign out_valid = s3_valid;
  assign out_mode  = s3_valid & s3_mode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
      s1_mode  <= 1'b0;
      s2_mode  <= 1'b0;
      s3_mode  <= 1'b0;
      out_sum  <= '0;
      out_ovf  <= '0;
    end else if (adv) begin
      s1_valid <= in_valid;
      s1_mode  <= in_mode;
      s2_valid <= s1_valid;
      s2_mode  <= s1_mode;
      s3_valid <= s2_valid;
      s3_mode  <= s2_mode;
      out_sum  <= res_sum;
      out_ovf  <= res_ovf;
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [15:0] a, b;
    assign a = in_a[16*i +: 16];
    assign b = in_b[16*i +: 16];

    // ---------------- S1: decode / swap / align ----------------
    logic        a_zero, b_zero, a_nan, b_nan, a_inf, b_inf, a_big;
    logic [14:0] mag_a, mag_b;
    logic [10:0] ma, mb, m_big, m_small;
    logic [4:0]  e_big, e_small, shift;
    logic [13:0] small_ext, small_shr, small_al;
    logic        lost;
    logic        spec_c;
    logic [15:0] spec_val_c;

    always_comb begin
      a_zero    = (a[14:10] == 5'd0);
      b_zero    = (b[14:10] == 5'd0);
      a_nan     = (a[14:10] == 5'h1F) && (a[9:0] != 10'd0);
      b_nan     = (b[14:10] == 5'h1F) && (b[9:0] != 10'd0);
      a_inf     = (a[14:10] == 5'h1F) && (a[9:0] == 10'd0);
      b_inf     = (b[14:10] == 5'h1F) && (b[9:0] == 10'd0);
      // Subnormals are flushed before the compare so they behave as zero.
      mag_a     = a_zero ? 15'd0 : a[14:0];
      mag_b     = b_zero ? 15'd0 : b[14:0];
      ma        = a_zero ? 11'd0 : {1'b1, a[9:0]};
      mb        = b_zero ? 11'd0 : {1'b1, b[9:0]};
      // Ties pick B, which also makes B's sign win on equal magnitudes.
      a_big     = (mag_a > mag_b);
      e_big     = a_big ? mag_a[14:10] : mag_b[14:10];
      e_small   = a_big ? mag_b[14:10] : mag_a[14:10];
      m_big     = a_big ? ma : mb;
      m_small   = a_big ? mb : ma;
      shift     = e_big - e_small;
      small_ext = {m_small, 3'b000};
      small_shr = small_ext >> shift;
      lost      = |(small_ext & ~(14'h3FFF << shift));
      if (shift >= 5'd14) small_al = {13'd0, |m_small};
      else                small_al = {small_shr[13:1], small_shr[0] | lost};

      spec_c     = 1'b0;
      spec_val_c = 16'h0000;
      if (a_nan || b_nan || (a_inf && b_inf && (a[15] != b[15]))) begin
        spec_c     = 1'b1;
        spec_val_c = QNAN;
      end else if (a_inf) begin
        spec_c     = 1'b1;
        spec_val_c = a;
      end else if (b_inf) begin
        spec_c     = 1'b1;
        spec_val_c = b;
      end
    end

    logic        s1_spec, s1_sign, s1_sub, s1_zsign;
    logic [15:0] s1_spec_val, s1_ia, s1_ib;
    logic [4:0]  s1_exp;
    logic [13:0] s1_m_big, s1_m_small;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s1_spec     <= 1'b0;
        s1_spec_val <= '0;
        s1_sign     <= 1'b0;
        s1_sub      <= 1'b0;
        s1_zsign    <= 1'b0;
        s1_exp      <= '0;
        s1_m_big    <= '0;
        s1_m_small  <= '0;
        s1_ia       <= '0;
        s1_ib       <= '0;
      end else if (adv) begin
        s1_spec     <= spec_c;
        s1_spec_val <= spec_val_c;
        s1_sign     <= a_big ? a[15] : b[15];
        s1_sub      <= a[15] ^ b[15];
        // A zero sum keeps a negative sign only for (-0)+(-0).
        s1_zsign    <= a[15] & b[15];
        s1_exp      <= e_big;
        s1_m_big    <= {m_big, 3'b000};
        s1_m_small  <= small_al;
        s1_ia       <= a;
        s1_ib       <= b;
      end
    end

    // ---------------- S2: add / subtract ----------------
    logic [14:0] fp_sum;
    logic [15:0] int_raw, int_res;
    logic        int_ovf;

    always_comb begin
      fp_sum  = s1_sub ? ({1'b0, s1_m_big} - {1'b0, s1_m_small})
                       : ({1'b0, s1_m_big} + {1'b0, s1_m_small});
      int_raw = s1_ia + s1_ib;
      int_ovf = (s1_ia[15] == s1_ib[15]) && (int_raw[15] != s1_ia[15]);
`ifdef INT_SAT_EN
      int_res = int_ovf ? (s1_ia[15] ? 16'h8000 : 16'h7FFF) : int_raw;
`else
      int_res = int_raw;
`endif
    end

    logic        s2_spec, s2_sign, s2_zsign, s2_int_ovf;
    logic [15:0] s2_spec_val, s2_int_res;
    logic [4:0]  s2_exp;
    logic [14:0] s2_sum;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        s2_spec     <= 1'b0;
        s2_spec_val <= '0;
        s2_sign     <= 1'b0;
        s2_zsign    <= 1'b0;
        s2_exp      <= '0;
        s2_sum      <= '0;
        s2_int_res  <= '0;
        s2_int_ovf  <= 1'b0;
      end else if (adv) begin
        s2_spec     <= s1_spec;
        s2_spec_val <= s1_spec_val;
        s2_sign     <= s1_sign;
        s2_zsign    <= s1_zsign;
        s2_exp      <= s1_exp;
        s2_sum      <= fp_sum;
        s2_int_res  <= int_res;
        s2_int_ovf  <= int_ovf;
      end
    end

    // ---------------- S3: normalise / round / pack ----------------
    logic [3:0]         lz;
    logic [13:0]        norm;
    logic [10:0]        mant;
    logic [11:0]        mant_r;
    logic [9:0]         frac;
    logic               guard, sticky, round_up;
    logic signed [6:0]  exp_n, exp_r;
    logic [15:0]        fp_res, lane_res;
    logic               fp_ovf, lane_ovf;

    always_comb begin
      lz = 4'd0;
      for (int k = 0; k < 14; k++) begin
        if (s2_sum[k]) lz = 4'(13 - k);
      end
      norm = s2_sum[13:0] << lz;
      if (s2_sum[14]) begin
        mant   = s2_sum[14:4];
        guard  = s2_sum[3];
        sticky = |s2_sum[2:0];
        exp_n  = $signed({2'b00, s2_exp}) + 7'sd1;
      end else begin
        mant   = norm[13:3];
        guard  = norm[2];
        sticky = |norm[1:0];
        exp_n  = $signed({2'b00, s2_exp}) - $signed({3'b000, lz});
      end
      round_up = guard & (sticky | mant[0]);
      mant_r   = {1'b0, mant} + {11'd0, round_up};
      if (mant_r[11]) begin
        exp_r = exp_n + 7'sd1;
        frac  = mant_r[10:1];
      end else begin
        exp_r = exp_n;
        frac  = mant_r[9:0];
      end

      fp_ovf = 1'b0;
      if (s2_spec) begin
        fp_res = s2_spec_val;
      end else if (s2_sum == 15'd0) begin
        fp_res = {s2_zsign, 15'd0};
      end else if (exp_r > 7'sd30) begin
        fp_res = {s2_sign, 5'h1F, 10'd0};
        fp_ovf = 1'b1;
      end else if (exp_r < 7'sd1) begin
        fp_res = 16'h0000;
      end else begin
        fp_res = {s2_sign, exp_r[4:0], frac};
      end

      lane_res = s2_mode ? fp_res : s2_int_res;
      lane_ovf = s2_mode ? fp_ovf : s2_int_ovf;
    end

    assign res_sum[16*i +: 16] = lane_res;
    assign res_ovf[i]          = lane_ovf;
  end

endmodule

// File: tb/tb_simd_fp_int_add_pipe.sv
// Testbench for simd_fp_int_add_pipe (LANES = 4). Expected results come from
// a real-number FP16 reference and an integer INT16 reference, queued when a
// beat is accepted and compared when the beat leaves the pipe.

module tb_simd_fp_int_add_pipe;

  localparam int LANES = 4;
  localparam int W     = LANES * 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic             in_mode = 1'b0;
  logic [W-1:0]     in_a = '0;
  logic [W-1:0]     in_b = '0;
  logic             out_valid;
  logic             out_ready = 1'b1;
  logic             out_mode;
  logic [W-1:0]     out_sum;
  logic [LANES-1:0] out_ovf;

  int n_checks = 0;
  int n_errors = 0;
  int cyc = 0;
  bit lat_mode = 1'b0;
  bit rnd_done = 1'b0;

  typedef struct {
    logic             mode;
    logic [W-1:0]     sum;
    logic [LANES-1:0] ovf;
    int               acc;
    bit               lat;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  simd_fp_int_add_pipe #(.LANES(LANES)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_mode   (in_mode),
    .in_a      (in_a),
    .in_b      (in_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_mode  (out_mode),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // ---------------- reference models ----------------
  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) repeat (e) r = r * 2.0;
    else        repeat (-e) r = r / 2.0;
    return r;
  endfunction

  function automatic real half_val(input logic [15:0] h);
    real mag = (1.0 + real'(h[9:0]) / 1024.0) * pow2(int'(h[14:10]) - 15);
    return h[15] ? -mag : mag;
  endfunction

  // returns {ovf, sum}
  function automatic logic [16:0] fp_model(input logic [15:0] a, input logic [15:0] b);
    bit   nan_a, nan_b, inf_a, inf_b, s;
    real  ra, rb, r, x, f, rem;
    int   e2, m, be;
    nan_a = (a[14:10] == 5'h1F) && (a[9:0] != 0);
    nan_b = (b[14:10] == 5'h1F) && (b[9:0] != 0);
    inf_a = (a[14:10] == 5'h1F) && (a[9:0] == 0);
    inf_b = (b[14:10] == 5'h1F) && (b[9:0] == 0);
    if (nan_a || nan_b || (inf_a && inf_b && (a[15] != b[15]))) return {1'b0, 16'h7E00};
    if (inf_a) return {1'b0, a};
    if (inf_b) return {1'b0, b};
    ra = (a[14:10] == 0) ? 0.0 : half_val(a);
    rb = (b[14:10] == 0) ? 0.0 : half_val(b);
    r  = ra + rb;
    if (r == 0.0) return {1'b0, a[15] & b[15], 15'h0000};
    s  = (r < 0.0);
    x  = s ? -r : r;
    e2 = 0;
    while (x >= 2.0) begin x = x / 2.0; e2++; end
    while (x < 1.0)  begin x = x * 2.0; e2--; end
    f   = x * 1024.0;
    m   = $rtoi(f);
    rem = f - real'(m);
    if (rem > 0.5 || (rem == 0.5 && (m % 2) == 1)) m++;
    if (m == 2048) begin m = 1024; e2++; end
    be = e2 + 15;
    if (be >= 31) return {1'b1, s, 5'h1F, 10'h000};
    if (be <= 0)  return 17'h0;
    return {1'b0, s, 5'(be), 10'(m)};
  endfunction

  function automatic logic [16:0] int_model(input logic [15:0] a, input logic [15:0] b);
    logic [15:0] r;
    logic        ov;
    r  = a + b;
    ov = (a[15] == b[15]) && (r[15] != a[15]);
`ifdef INT_SAT_EN
    if (ov) r = a[15] ? 16'h8000 : 16'h7FFF;
`endif
    return {ov, r};
  endfunction

  // ---------------- driver ----------------
  task automatic send_beat(input logic mode, input logic [W-1:0] a, input logic [W-1:0] b);
    exp_t        e;
    logic [16:0] r;
    int          waitc = 0;
    in_valid = 1'b1;
    in_mode  = mode;
    in_a     = a;
    in_b     = b;
    @(negedge clk);
    while (!in_ready && waitc < 50) begin
      waitc++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
      in_valid = 1'b0;
      @(posedge clk);
      #1;
      return;
    end
    e.mode = mode;
    for (int l = 0; l < LANES; l++) begin
      r = mode ? fp_model(a[16*l +: 16], b[16*l +: 16]) : int_model(a[16*l +: 16], b[16*l +: 16]);
      e.sum[16*l +: 16] = r[15:0];
      e.ovf[l]          = r[16];
    end
    e.acc = cyc;
    e.lat = lat_mode;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int k = 0;
    while (sb_q.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (sb_q.size() != 0) chk("drain_timeout", sb_q.size(), 0);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic gen_ops(output logic [W-1:0] a, output logic [W-1:0] b);
    logic [15:0] x, y;
    for (int l = 0; l < LANES; l++) begin
      x = 16'($urandom);
      if ($urandom_range(0, 1) == 1)
        y = {1'($urandom), 5'(x[14:10] - 5'($urandom_range(0, 2))), 10'($urandom)};
      else
        y = 16'($urandom);
      a[16*l +: 16] = x;
      b[16*l +: 16] = y;
    end
  endtask

  // ---------------- monitor ----------------
  logic             hold_prev = 1'b0;
  logic [W-1:0]     prev_sum;
  logic [LANES-1:0] prev_ovf;
  logic             prev_mode;

  always @(negedge clk) begin
    if (rst_n) begin
      if (hold_prev) begin
        chk("hold_sum", out_sum, prev_sum);
        chk("hold_ovf", out_ovf, prev_ovf);
        chk("hold_mode", out_mode, prev_mode);
      end
      if (out_valid && !out_ready) chk("in_ready_stall", in_ready, 0);
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          chk("stale_beat", out_valid, 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("sum", out_sum, mon_e.sum);
          chk("ovf", out_ovf, mon_e.ovf);
          chk("mode", out_mode, mon_e.mode);
          if (mon_e.lat) chk("latency", cyc - mon_e.acc, 3);
        end
      end
      hold_prev = out_valid && !out_ready;
      prev_sum  = out_sum;
      prev_ovf  = out_ovf;
      prev_mode = out_mode;
    end else begin
      hold_prev = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  logic [W-1:0] ra_v, rb_v;

  initial begin
    rst_n     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_sum", out_sum, 0);
    chk("rst_out_ovf", out_ovf, 0);
    chk("rst_out_mode", out_mode, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("rst_in_ready", in_ready, 1);

    // directed beats, out_ready held high so latency is checked on each
    lat_mode = 1'b1;
    send_beat(1'b1, {16'h3C01, 16'h3C00, 16'h3C00, 16'h3C00},
                    {16'h1000, 16'h1000, 16'hBC00, 16'h3C00});
    drain();
    send_beat(1'b1, {16'h7BFF, 16'h7C00, 16'h7E00, 16'h7C00},
                    {16'h7BFF, 16'hFC00, 16'h3C00, 16'h3C00});
    send_beat(1'b1, {16'h0001, 16'h8000, 16'h0000, 16'h3C00},
                    {16'h0000, 16'h8000, 16'h8000, 16'hB800});
    send_beat(1'b0, {16'h7FFF, 16'h8000, 16'h1234, 16'hFFFF},
                    {16'h0001, 16'hFFFF, 16'h0001, 16'h0001});
    send_beat(1'b1, {16'hFC00, 16'h3C00, 16'hC000, 16'h0400},
                    {16'h3C00, 16'hFE00, 16'h3C00, 16'h8400});
    drain();
    lat_mode = 1'b0;

    // backpressure: 8 mixed beats, out_ready low for 5 cycles mid-stream
    fork
      begin
        for (int k = 0; k < 8; k++) begin
          gen_ops(ra_v, rb_v);
          send_beat(1'(k % 3 != 1), ra_v, rb_v);
        end
      end
      begin
        repeat (4) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // random beats under random backpressure
    rnd_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          gen_ops(ra_v, rb_v);
          send_beat(1'($urandom_range(0, 1)), ra_v, rb_v);
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // reset with three beats in flight
    lat_mode = 1'b1;
    send_beat(1'b1, {4{16'h3C00}}, {4{16'h3C00}});
    send_beat(1'b0, {4{16'h1111}}, {4{16'h2222}});
    send_beat(1'b1, {4{16'h4000}}, {4{16'h4000}});
    chk("pre_rst_out_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_out_sum", out_sum, 0);
    chk("mid_rst_out_ovf", out_ovf, 0);
    chk("mid_rst_out_mode", out_mode, 0);
    sb_q.delete();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_in_ready", in_ready, 1);
    send_beat(1'b0, {16'h0001, 16'h0002, 16'h0003, 16'h0004},
                    {16'h0010, 16'h0020, 16'h0030, 16'h0040});
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
